// File: rtl/pdm_pkg.sv
// Shared types and default constants for the PCM-to-PDM playback block.
// Holds the playback FSM encoding and a counter-width helper.
package pdm_pkg;

    localparam int CLK_DIV_HALF_DEF = 25;
    localparam int OVERSAMPLE_DEF   = 64;
    localparam int FIFO_DEPTH_DEF   = 16;

    localparam logic [15:0] SIGN_FLIP = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } pdm_state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pcm_fifo.sv
// Synchronous 16-bit sample FIFO with occupancy count.
// Read data is first-word-fall-through; full/empty gate push/pop.
module pcm_fifo
    import pdm_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [15:0]              data_i,
    input  logic                     pop_i,
    output logic [15:0]              data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        full_o  = (count_q == (AW+1)'(DEPTH));
        empty_o = (count_q == '0);
        // Fullness is judged before any same-cycle pop.
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/pdm_playback.sv
// PCM byte stream to PDM bit stream: byte pairing, sample FIFO,
// bit-clock divider, playback FSM and first-order sigma-delta.
module pdm_playback
    import pdm_pkg::*;
#(
    parameter int CLK_DIV_HALF = CLK_DIV_HALF_DEF,
    parameter int OVERSAMPLE   = OVERSAMPLE_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable_i,
    input  logic [7:0]                    byte_i,
    input  logic                          byte_valid_i,
    output logic                          pdm_clk_o,
    output logic                          pdm_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overflow_o,
    output logic                          underrun_o
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = cnt_w(CLK_DIV_HALF);
    localparam int BW = cnt_w(OVERSAMPLE);

    pdm_state_e state_q, state_d;

    logic          phase_q, phase_d;
    logic [7:0]    low_q, low_d;
    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [15:0]   acc_q, acc_d;
    logic [15:0]   sample_q, sample_d;
    logic          pclk_q, pclk_d;
    logic          data_q, data_d;
    logic          ovf_q, ovf_d;
    logic          und_q, und_d;

    logic          push, pop;
    logic [15:0]   fifo_data;
    logic          fifo_full, fifo_empty;
    logic [LW-1:0] level;
    logic          run_en;
    logic          div_wrap, step, load;
    logic [15:0]   cur_sample;
    logic [16:0]   acc17;

    pcm_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  ({byte_i, low_q}),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable_i) state_d = ST_PRIME;
            end
            ST_PRIME: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (level >= LW'(FIFO_DEPTH / 2)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Dropping enable silences the outputs on the very next edge.
    always_comb begin
        run_en = 1'b0;
        unique case (state_q)
            ST_RUN:  run_en = enable_i;
            default: run_en = 1'b0;
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        low_d   = low_q;
        if (byte_valid_i) begin
            phase_d = !phase_q;
            if (!phase_q) low_d = byte_i;
        end
        push = byte_valid_i && phase_q;
        ovf_d = ovf_q | (push & fifo_full);
    end

    always_comb begin
        div_wrap   = (div_q == DW'(CLK_DIV_HALF - 1));
        step       = run_en && div_wrap && pclk_q;
        load       = step && (bit_q == '0);
        pop        = load && !fifo_empty;
        cur_sample = sample_q;
        if (load) cur_sample = fifo_empty ? 16'h0000 : fifo_data;
        // Offset-binary add; the carry out is the PDM bit.
        acc17 = {1'b0, acc_q} + {1'b0, cur_sample ^ SIGN_FLIP};
        und_d = und_q | (load & fifo_empty);

        div_d    = '0;
        pclk_d   = 1'b0;
        data_d   = 1'b0;
        bit_d    = '0;
        acc_d    = '0;
        sample_d = '0;
        if (run_en) begin
            div_d    = div_wrap ? '0 : div_q + 1'b1;
            pclk_d   = div_wrap ? !pclk_q : pclk_q;
            data_d   = data_q;
            bit_d    = bit_q;
            acc_d    = acc_q;
            sample_d = sample_q;
            if (step) begin
                data_d   = acc17[16];
                acc_d    = acc17[15:0];
                sample_d = cur_sample;
                bit_d    = (bit_q == BW'(OVERSAMPLE - 1)) ? '0 : bit_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= 1'b0;
            low_q    <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            acc_q    <= '0;
            sample_q <= '0;
            pclk_q   <= 1'b0;
            data_q   <= 1'b0;
            ovf_q    <= 1'b0;
            und_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            low_q    <= low_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            acc_q    <= acc_d;
            sample_q <= sample_d;
            pclk_q   <= pclk_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            und_q    <= und_d;
        end
    end

    assign pdm_clk_o  = pclk_q;
    assign pdm_data_o = data_q;
    assign level_o    = level;
    assign overflow_o = ovf_q;
    assign underrun_o = und_q;

endmodule

// File: doc/pdm_playback.md
PDM_PLAYBACK -- requirements
Module: pdm_playback

Interface
- REQ-001 SHALL have parameter CLK_DIV_HALF, default 25, meaning clk cycles per pdm_clk_o half-period (100 MHz -> 2 MHz).
- REQ-002 SHALL have parameter OVERSAMPLE, default 64, meaning PDM bits per PCM sample.
- REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning 16-bit sample entries, power of two.
- REQ-004 SHALL have port clk, input, 1, sole clock; all logic on posedge.
- REQ-005 SHALL have port rst, input, 1, synchronous, active-high reset.
- REQ-006 SHALL have port enable_i, input, 1, playback enable.
- REQ-007 SHALL have port byte_i, input, 8, PCM byte stream, little-endian.
- REQ-008 SHALL have port byte_valid_i, input, 1, single-cycle strobe qualifying byte_i.
- REQ-009 SHALL have port pdm_clk_o, output, 1, PDM bit clock to the amplifier.
- REQ-010 SHALL have port pdm_data_o, output, 1, PDM bit stream.
- REQ-011 SHALL have port level_o, output, $clog2(FIFO_DEPTH)+1, FIFO occupancy in samples.
- REQ-012 SHALL have port overflow_o, output, 1, sticky; a sample was dropped.
- REQ-013 SHALL have port underrun_o, output, 1, sticky; silence was inserted.

Function
- REQ-014 SHALL assemble bytes with a phase flag: phase 0 stores byte_i as the low byte; phase 1 forms {byte_i, low} and pushes it; the phase toggles on every byte_valid_i.
- REQ-015 SHALL drop the push and set overflow_o when FIFO is full; fullness is evaluated before a same-cycle pop.
- REQ-016 SHALL apply push and pop in the same cycle, leaving level_o unchanged.
- REQ-017 SHALL have FSM states IDLE, PRIME, RUN; IDLE->PRIME when enable_i=1; PRIME->RUN when level_o >= FIFO_DEPTH/2; PRIME or RUN -> IDLE when enable_i=0 (next cycle).
- REQ-018 SHALL, in IDLE/PRIME, hold pdm_clk_o=0, pdm_data_o=0, and clear the divider, bit counter and accumulator; the FIFO still accepts bytes.
- REQ-019 SHALL, in RUN, toggle pdm_clk_o when the divider reaches CLK_DIV_HALF-1 (divider then wraps to 0); the first toggle is CLK_DIV_HALF cycles after entering RUN.
- REQ-020 SHALL define a modulator step as the cycle pdm_clk_o goes 1->0; pdm_data_o is registered on that cycle, stable across the next rising edge.
- REQ-021 SHALL load the current sample at the step where the bit counter is 0: pop the FIFO if non-empty, else use 0x0000 and set underrun_o; the first step in RUN loads.
- REQ-022 SHALL count 0..OVERSAMPLE-1 on the bit counter, one per step, then wrap.
- REQ-023 SHALL treat the sample as signed 16-bit; each step computes acc17 = acc[15:0] + (sample XOR 0x8000), sets pdm_data_o = acc17[16], and stores acc = acc17[15:0]; ones density = (sample+32768)/65536.
- REQ-024 SHALL keep overflow_o and underrun_o cleared only by rst, not by enable_i.

Reset
- REQ-025 SHALL, on rst, set state=IDLE, FIFO empty, level_o=0, phase=0, divider=0, bit counter=0, acc=0, and all outputs 0.
- REQ-026 SHALL give rst priority over every other event, including a mid-sample reset and a reset coincident with byte_valid_i.

Structure
- REQ-027 SHALL place the state enum (IDLE/PRIME/RUN) and default parameter constants in shared package pdm_pkg.
- REQ-028 SHALL implement the sample buffer as one sub-module, pcm_fifo (sync FIFO, 16-bit, count output); divider, FSM and modulator live in pdm_playback.

Verification
- REQ-029 SHALL cover: 16 byte pairs for 0x0000, enable -> RUN after 8th sample; pdm_data_o = 0,1,0,1...; pdm_clk_o period 50 cycles.
- REQ-030 SHALL cover: sample 0x8000 -> 64 zero bits; sample 0x7FFF -> 64 bits with exactly one 0 (the first, from acc=0).
- REQ-031 SHALL cover: 17 samples pushed with enable_i=0 -> level_o=16, overflow_o=1; the 17th sample is absent from playback.
- REQ-032 SHALL cover: FIFO drained in RUN -> underrun_o=1, pattern 0101, state stays RUN; new pushes play at the next sample boundary.
- REQ-033 SHALL cover: enable_i dropped mid-sample -> next cycle pdm_clk_o=0, pdm_data_o=0, state IDLE; FIFO contents retained.
- REQ-034 SHALL cover: rst asserted with a lone low byte pending -> phase cleared; the next two bytes form one sample.
